// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared definitions for the NoC local injection arbiter: default flit width and FSM state encoding.
package noc_local_inject_arbiter_pkg;

  localparam int NOC_DATA_W = 32;

  typedef enum logic {
    NOC_ARB_IDLE = 1'b0,
    NOC_ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_local_inject_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after ptr (mod NUM_REQ),
// returned as one-hot grant and index.
module noc_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // The pointer itself is searched last, so the previous winner has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC local injection port between NUM_REQ requesters.
// Optional per-requester packet counters when NOC_ARB_STATS_EN is defined.
module noc_local_inject_arbiter
  import noc_local_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = NOC_DATA_W
`ifdef NOC_ARB_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                        noc_clk,
  input  logic                        noc_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]          req_is_header,
  input  logic [NUM_REQ-1:0]          req_is_tail,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_flit,
  output logic                        out_is_header,
  output logic                        out_is_tail,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef NOC_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [NUM_REQ*CNT_W-1:0]    stat_pkt_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]     win_idx;
  logic              xfer_tail;

  // Only headers may open a packet; stray body flits wait unserved.
  assign eligible = req_valid & req_is_header;

  noc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt     (win_oh),
    .gnt_idx (win_idx)
  );

  always_comb begin
    out_valid     = 1'b0;
    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    req_ready     = '0;
    if (state_q == NOC_ARB_LOCK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == IW'(i)) begin
          out_valid     = req_valid[i];
          out_flit      = req_flit[i*DATA_W +: DATA_W];
          out_is_header = req_is_header[i];
          out_is_tail   = req_is_tail[i];
          req_ready[i]  = out_ready;
        end
      end
    end
  end

  assign xfer_tail = out_valid & out_ready & out_is_tail;
  assign busy      = (state_q == NOC_ARB_LOCK);
  assign grant_id  = grant_id_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      NOC_ARB_IDLE: begin
        if (|win_oh) begin
          state_d    = NOC_ARB_LOCK;
          grant_id_d = win_idx;
          rr_ptr_d   = win_idx;
        end
      end
      NOC_ARB_LOCK: begin
        if (xfer_tail) state_d = NOC_ARB_IDLE;
      end
      default: state_d = NOC_ARB_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state_q    <= NOC_ARB_IDLE;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  // Clear takes priority over a same-cycle tail; counters saturate at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (xfer_tail && (grant_id_q == IW'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!noc_rst_n) cnt_q[i] <= '0;
      else            cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Self-checking bench for noc_local_inject_arbiter: directed vector table, packet-level
// reference model under random and continuous traffic, and counter checks when NOC_ARB_STATS_EN is set.
module tb_noc_local_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
`ifdef NOC_ARB_STATS_EN
  localparam int CNT_W   = 4;
`endif

  logic                       noc_clk;
  logic                       noc_rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DATA_W-1:0]  req_flit;
  logic [NUM_REQ-1:0]         req_is_header;
  logic [NUM_REQ-1:0]         req_is_tail;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_flit;
  logic                       out_is_header;
  logic                       out_is_tail;
  logic [1:0]                 grant_id;
  logic                       busy;
`ifdef NOC_ARB_STATS_EN
  logic                       stat_clr;
  logic [NUM_REQ*CNT_W-1:0]   stat_pkt_cnt;
`endif

  noc_local_inject_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
`ifdef NOC_ARB_STATS_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst_n     (noc_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_flit      (req_flit),
    .req_is_header (req_is_header),
    .req_is_tail   (req_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .grant_id      (grant_id),
    .busy          (busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_pkt_cnt  (stat_pkt_cnt)
`endif
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] v, h, t;
    logic [7:0] f1;
    logic       ordy;
    logic       e_busy;
    logic [1:0] e_gid;
    logic       e_ov;
    logic [7:0] e_flit;
    logic [3:0] e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] h,
                              input logic [3:0] t, input logic [7:0] f1, input logic ordy,
                              input logic eb, input logic [1:0] eg, input logic eo,
                              input logic [7:0] ef, input logic [3:0] er);
    vec_t r;
    r.rst = rst; r.v = v; r.h = h; r.t = t; r.f1 = f1; r.ordy = ordy;
    r.e_busy = eb; r.e_gid = eg; r.e_ov = eo; r.e_flit = ef; r.e_rdy = er;
    return r;
  endfunction

  vec_t tbl[$];

  // ---------------- packet-level reference model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        h;
    logic        t;
  } flit_t;

  flit_t rq [NUM_REQ][$];
  int    glog[$];

  task automatic do_reset();
    noc_rst_n     = 1'b0;
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
    out_ready     = 1'b0;
    @(posedge noc_clk); #1;
    noc_rst_n = 1'b1;
  endtask

  // Runs queued packets through the DUT; the model owns the port per packet and
  // hands it round-robin among requesters showing a header while the port is free.
  task automatic run_model(input bit cont, input int npkt, input int max_len);
    int         owner, ptr, cyc, len, idx;
    logic [3:0] v, e_rdy;
    flit_t      fl;
    bit         pending;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      for (int p = 0; p < npkt; p++) begin
        len = cont ? 2 : $urandom_range(1, max_len);
        for (int f = 0; f < len; f++) begin
          fl.d = {8'(i), 8'(p), 8'(f), 8'h5A};
          fl.h = (f == 0);
          fl.t = (f == len - 1);
          rq[i].push_back(fl);
        end
      end
    end
    glog.delete();
    owner = -1;
    ptr   = NUM_REQ - 1;
    cyc   = 0;
    pending = 1'b1;
    while (pending && cyc < 4000) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        v[i] = (rq[i].size() > 0) && (cont || ($urandom_range(0, 3) != 0));
        fl   = (rq[i].size() > 0) ? rq[i][0] : '0;
        req_valid[i]             = v[i];
        req_is_header[i]         = fl.h;
        req_is_tail[i]           = fl.t;
        req_flit[i*DATA_W +: 32] = fl.d;
      end
      out_ready = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      #4;
      chk("m_busy", busy, owner >= 0);
      e_rdy = '0;
      if (owner >= 0) begin
        chk("m_grant_id", grant_id, owner);
        chk("m_out_valid", out_valid, v[owner]);
        if (v[owner]) begin
          fl = rq[owner][0];
          chk("m_out_flit", out_flit, fl.d);
          chk("m_out_hdr_tail", {out_is_header, out_is_tail}, {fl.h, fl.t});
        end
        e_rdy[owner] = out_ready;
      end else begin
        chk("m_out_valid_idle", out_valid, 0);
      end
      chk("m_req_ready", req_ready, e_rdy);
      if (owner < 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (ptr + k) % NUM_REQ;
          if (v[idx] && rq[idx][0].h) begin
            owner = idx;
            ptr   = idx;
            glog.push_back(idx);
            break;
          end
        end
      end else if (v[owner] && out_ready) begin
        fl = rq[owner].pop_front();
        if (fl.t) owner = -1;
      end
      pending = (owner >= 0);
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) pending = 1'b1;
      @(posedge noc_clk); #1;
      cyc++;
    end
    if (pending) chk("m_timeout", 0, 1);
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] v4;
    int idx;
`ifdef NOC_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_grant_id", grant_id, 0);

    //      rst  v     h     t     f1     ordy | busy gid ov flit   rdy
    // two single-flit headers: req0 first, bubble, then req2
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h5, 8'hC1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h5, 8'hC1, 1, 1, 0, 1, 8'hC0, 4'h1));
    tbl.push_back(mk(0, 4'h4, 4'h4, 4'h4, 8'hC1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h4, 4'h4, 4'h4, 8'hC1, 1, 1, 2, 1, 8'hC2, 4'h4));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 2, 0, 8'h00, 4'h0));
    // req1 4-flit packet A1..A4 while req3 header waits
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 2, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'hA, 4'hA, 4'h8, 8'hA1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'hA, 4'hA, 4'h8, 8'hA1, 1, 1, 1, 1, 8'hA1, 4'h2));
    tbl.push_back(mk(0, 4'hA, 4'h8, 4'h8, 8'hA2, 1, 1, 1, 1, 8'hA2, 4'h2));
    tbl.push_back(mk(0, 4'hA, 4'h8, 4'h8, 8'hA3, 1, 1, 1, 1, 8'hA3, 4'h2));
    tbl.push_back(mk(0, 4'hA, 4'h8, 4'hA, 8'hA4, 1, 1, 1, 1, 8'hA4, 4'h2));
    tbl.push_back(mk(0, 4'h8, 4'h8, 4'h8, 8'hC1, 1, 0, 1, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h8, 4'h8, 4'h8, 8'hC1, 1, 1, 3, 1, 8'hC3, 4'h8));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 3, 0, 8'h00, 4'h0));
    // stall 5 cycles, owner drops valid 2 cycles, stray header mid-packet
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 3, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 4'h0, 8'hB1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 4'h0, 8'hB1, 1, 1, 1, 1, 8'hB1, 4'h2));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 8'hB2, 0, 1, 1, 1, 8'hB2, 4'h0));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 8'hB2, 1, 1, 1, 0, 8'h00, 4'h2));
    tbl.push_back(mk(0, 4'h2, 4'h2, 4'h0, 8'hB2, 1, 1, 1, 1, 8'hB2, 4'h2));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h2, 8'hB3, 1, 1, 1, 1, 8'hB3, 4'h2));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 1, 0, 8'h00, 4'h0));
    // req0 body flit ignored in idle; reset after flit 2 abandons req2, then req0 wins
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 1, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h5, 4'h4, 4'h0, 8'hC1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h5, 4'h4, 4'h0, 8'hC1, 1, 1, 2, 1, 8'hC2, 4'h4));
    tbl.push_back(mk(0, 4'h5, 4'h0, 4'h0, 8'hC1, 1, 1, 2, 1, 8'hC2, 4'h4));
    tbl.push_back(mk(1, 4'h5, 4'h0, 4'h0, 8'hC1, 1, 1, 2, 1, 8'hC2, 4'h4));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h5, 8'hC1, 1, 0, 0, 0, 8'h00, 4'h0));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h5, 8'hC1, 1, 1, 0, 1, 8'hC0, 4'h1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 8'hC1, 1, 0, 0, 0, 8'h00, 4'h0));

    foreach (tbl[n]) begin
      noc_rst_n     = !tbl[n].rst;
      req_valid     = tbl[n].v;
      req_is_header = tbl[n].h;
      req_is_tail   = tbl[n].t;
      for (int i = 0; i < NUM_REQ; i++)
        req_flit[i*DATA_W +: DATA_W] = (i == 1) ? {24'h0, tbl[n].f1} : 32'hC0 + 32'(i);
      out_ready = tbl[n].ordy;
      #4;
      chk($sformatf("v%0d_busy", n), busy, tbl[n].e_busy);
      chk($sformatf("v%0d_grant_id", n), grant_id, tbl[n].e_gid);
      chk($sformatf("v%0d_out_valid", n), out_valid, tbl[n].e_ov);
      if (tbl[n].e_ov) chk($sformatf("v%0d_out_flit", n), out_flit, {24'h0, tbl[n].e_flit});
      chk($sformatf("v%0d_req_ready", n), req_ready, tbl[n].e_rdy);
      @(posedge noc_clk); #1;
    end
    noc_rst_n = 1'b1;

    // continuous 2-flit packets from all requesters: strict rotation 0,1,2,3,...
    do_reset();
    run_model(1'b1, 3, 2);
    chk("rr_grant_count", glog.size(), 12);
    for (int k = 0; k < glog.size() && k < 12; k++)
      chk($sformatf("rr_order_%0d", k), glog[k], k % NUM_REQ);

    // random valid/ready traffic with packets of 1..4 flits
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_model(1'b0, 8, 4);
    end

`ifdef NOC_ARB_STATS_EN
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < 2; c++) begin
        req_valid = 4'h4; req_is_header = 4'h4; req_is_tail = 4'h4;
        @(posedge noc_clk); #1;
      end
    end
    req_valid = '0;
    #4;
    chk("stat_cnt2_sat", stat_pkt_cnt[2*CNT_W +: CNT_W], 15);
    chk("stat_cnt0", stat_pkt_cnt[0 +: CNT_W], 0);
    @(posedge noc_clk); #1;
    stat_clr = 1'b1;
    @(posedge noc_clk); #1;
    stat_clr = 1'b0;
    #4;
    chk("stat_cnt2_clr", stat_pkt_cnt[2*CNT_W +: CNT_W], 0);
    @(posedge noc_clk); #1;
`endif

    v4 = '0;
    idx = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
